match_req_dispatch: RTL and testbench
=====================================

MATCH_REQ_DISPATCH -- requirements
Module: match_req_dispatch

Interface
REQ-001 The block SHALL have these parameters: L, default `LAZY_LEN, requests per group; C, default `NUM_MATCH_REQ_CH, match request channels; TAG_BITS, default `LAZY_LEN_LOG2, tag width; AW, default 32, per-request payload width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_group_valid  input  1  upstream request group offered.
REQ-005 req_group_ready  output  1  group accepted when valid && ready.
REQ-006 req_group_strb  input  L  bit i set = request i is live.
REQ-007 req_group_addr  input  L*AW  payload of request i at [i*AW +: AW].
REQ-008 req_valid  output  C  per-channel request valid.
REQ-009 req_ready  input  C  per-channel request ready.
REQ-010 req_tag  output  C*TAG_BITS  lazy index carried by channel k.
REQ-011 req_addr  output  C*AW  payload carried by channel k.
REQ-012 sync_group_valid  output  1  one-cycle pulse announcing a new group to the response collector.
REQ-013 sync_group_strb  output  L  strobe of the announced group, valid only while sync_group_valid is 1.
REQ-014 resp_group_done  input  1  pulse: the response collector's grouped-response handshake completed.

Function
REQ-015 The FSM SHALL have states IDLE, DISPATCH and WAIT; req_group_ready SHALL be 1 exactly in IDLE.
REQ-016 On accept in IDLE, the block SHALL latch strb into a pending mask and addr into a payload buffer, and SHALL go to DISPATCH if strb != 0, else to WAIT.
REQ-017 sync_group_valid SHALL be 1 for exactly the one cycle after acceptance, with sync_group_strb equal to the latched strb; this includes strb == 0.
REQ-018 Each channel k SHALL own an output register (valid, tag, addr); the register is free when req_valid[k]==0 or req_valid[k]&&req_ready[k] in the current cycle.
REQ-019 Each cycle in DISPATCH, the free channels, taken in ascending k, SHALL load the pending indices in ascending order. The lowest pending index goes to the lowest free channel.
REQ-020 On load, the channel's tag SHALL be the index i (i[TAG_BITS-1:0]) and its addr SHALL be payload i; bit i SHALL clear from the pending mask in the same edge.
REQ-021 A free channel with no pending index left SHALL drop req_valid to 0.
REQ-022 Once req_valid[k] is 1, req_tag and req_addr of channel k SHALL hold stable until req_ready[k] is sampled 1.
REQ-023 Each live index SHALL be issued exactly once per group; no index outside strb SHALL be issued.
REQ-024 DISPATCH SHALL go to WAIT when the pending mask is 0 and all req_valid are 0 after the edge.
REQ-025 WAIT SHALL go to IDLE on resp_group_done==1; resp_group_done SHALL be ignored in IDLE and DISPATCH.
REQ-026 Minimum latency SHALL be: accept at cycle 0, first req_valid at cycle 1.
REQ-027 At most one group SHALL be outstanding between acceptance and resp_group_done.

Reset
REQ-028 While rst_n==0, the block SHALL enter IDLE and clear the pending mask.
REQ-029 While rst_n==0, req_valid, sync_group_valid and sync_group_strb SHALL be 0, and req_group_ready SHALL be 1 in the first cycle after release.
REQ-030 Reset mid-DISPATCH or mid-WAIT SHALL discard all pending and in-flight requests without issuing further requests.

Verification
REQ-031 L=4, C=2, strb=1111, req_ready=11 always: cycle 1 tags (0,1) with sync pulse strb=1111; cycle 2 tags (2,3); cycle 3 req_valid=00; WAIT until done, then IDLE.
REQ-032 strb=1010, req_ready=11: cycle 1 ch0 tag1, ch1 tag3; no other tags issued.
REQ-033 strb=1111, req_ready[1]=0 for 3 cycles: ch1 holds tag1/addr1 stable; ch0 issues tags 0, 2, 3 in successive cycles.
REQ-034 strb=0000: sync pulse with strb=0000, no req_valid, WAIT until resp_group_done, req_group_ready=0 throughout.
REQ-035 rst_n=0 asserted during DISPATCH with tag 3 still pending: req_valid=00 next cycle; tag 3 never issued after reset; req_group_ready=1 after release.
REQ-036 resp_group_done pulsed in IDLE or DISPATCH: no state change; a second group is offered during WAIT: req_group_ready stays 0 until done.

Source files
------------

// File: rtl/match_req_dispatch.sv
// Splits an accepted request group into per-channel match requests, lowest
// pending index to lowest free channel, and announces each group to the collector.
`ifndef LAZY_LEN
`define LAZY_LEN 4
`endif
`ifndef NUM_MATCH_REQ_CH
`define NUM_MATCH_REQ_CH 2
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 2
`endif

module match_req_dispatch #(
  parameter int L        = `LAZY_LEN,
  parameter int C        = `NUM_MATCH_REQ_CH,
  parameter int TAG_BITS = `LAZY_LEN_LOG2,
  parameter int AW       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_group_valid,
  output logic                  req_group_ready,
  input  logic [L-1:0]          req_group_strb,
  input  logic [L*AW-1:0]       req_group_addr,
  output logic [C-1:0]          req_valid,
  input  logic [C-1:0]          req_ready,
  output logic [C*TAG_BITS-1:0] req_tag,
  output logic [C*AW-1:0]       req_addr,
  output logic                  sync_group_valid,
  output logic [L-1:0]          sync_group_strb,
  input  logic                  resp_group_done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_WAIT     = 2'd2;

  logic [1:0]            state_r, state_nxt_s;
  logic [L-1:0]          pending_r, pending_nxt_s, src_mask_s;
  logic [L*AW-1:0]       payload_r, src_payload_s;
  logic [C-1:0]          valid_r, valid_nxt_s;
  logic [C*TAG_BITS-1:0] tag_r, tag_nxt_s;
  logic [C*AW-1:0]       addr_r, addr_nxt_s;
  logic                  sync_valid_r;
  logic [L-1:0]          sync_strb_r;
  logic                  accept_s;

  assign accept_s         = (state_r == ST_IDLE) && req_group_valid;
  assign req_group_ready  = (state_r == ST_IDLE);
  assign req_valid        = valid_r;
  assign req_tag          = tag_r;
  assign req_addr         = addr_r;
  assign sync_group_valid = sync_valid_r;
  assign sync_group_strb  = sync_strb_r;

  // Selects the index source: the incoming group on accept so channels load in
  // the same edge, otherwise the latched pending mask and payload buffer.
  always_comb begin
    src_mask_s    = {L{1'b0}};
    src_payload_s = payload_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          src_mask_s    = req_group_strb;
          src_payload_s = req_group_addr;
        end else begin
          src_mask_s    = {L{1'b0}};
          src_payload_s = payload_r;
        end
      end
      ST_DISPATCH: begin
        src_mask_s    = pending_r;
        src_payload_s = payload_r;
      end
      default: begin
        src_mask_s    = {L{1'b0}};
        src_payload_s = payload_r;
      end
    endcase
  end

  // Free channels in ascending order each take the lowest remaining index.
  always_comb begin
    logic [L-1:0] rem;
    logic         found;
    rem         = src_mask_s;
    found       = 1'b0;
    valid_nxt_s = valid_r;
    tag_nxt_s   = tag_r;
    addr_nxt_s  = addr_r;
    for (int k = 0; k < C; k++) begin
      if (!valid_r[k] || req_ready[k]) begin
        found          = 1'b0;
        valid_nxt_s[k] = 1'b0;
        for (int i = 0; i < L; i++) begin
          if (!found && rem[i]) begin
            found                              = 1'b1;
            valid_nxt_s[k]                     = 1'b1;
            tag_nxt_s[k*TAG_BITS +: TAG_BITS]  = TAG_BITS'(i);
            addr_nxt_s[k*AW +: AW]             = src_payload_s[i*AW +: AW];
            rem[i]                             = 1'b0;
          end else begin
            rem[i] = rem[i];
          end
        end
      end else begin
        valid_nxt_s[k] = 1'b1;
      end
    end
    pending_nxt_s = rem;
  end

  // Group-level sequencing: one group in flight until the collector reports done.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (req_group_strb != {L{1'b0}}) ? ST_DISPATCH : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        if ((pending_nxt_s == {L{1'b0}}) && (valid_nxt_s == {C{1'b0}})) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_DISPATCH;
        end
      end
      ST_WAIT: begin
        if (resp_group_done) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, pending mask, channel registers and sync pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pending_r    <= {L{1'b0}};
      payload_r    <= {(L*AW){1'b0}};
      valid_r      <= {C{1'b0}};
      tag_r        <= {(C*TAG_BITS){1'b0}};
      addr_r       <= {(C*AW){1'b0}};
      sync_valid_r <= 1'b0;
      sync_strb_r  <= {L{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      pending_r    <= pending_nxt_s;
      payload_r    <= src_payload_s;
      valid_r      <= valid_nxt_s;
      tag_r        <= tag_nxt_s;
      addr_r       <= addr_nxt_s;
      sync_valid_r <= accept_s;
      sync_strb_r  <= accept_s ? req_group_strb : {L{1'b0}};
    end
  end

endmodule

// File: tb/tb_match_req_dispatch.sv
// Directed bench for match_req_dispatch with L=4, C=2, TAG_BITS=2, AW=32.
module tb_match_req_dispatch;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_group_valid;
  logic         req_group_ready;
  logic [3:0]   req_group_strb;
  logic [127:0] req_group_addr;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_tag;
  logic [63:0]  req_addr;
  logic         sync_group_valid;
  logic [3:0]   sync_group_strb;
  logic         resp_group_done;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] A0 = 32'hA000_0010;
  localparam logic [31:0] A1 = 32'hA000_0021;
  localparam logic [31:0] A2 = 32'hA000_0032;
  localparam logic [31:0] A3 = 32'hA000_0043;

  match_req_dispatch #(.L(4), .C(2), .TAG_BITS(2), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_group_valid(req_group_valid), .req_group_ready(req_group_ready),
    .req_group_strb(req_group_strb), .req_group_addr(req_group_addr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_addr(req_addr),
    .sync_group_valid(sync_group_valid), .sync_group_strb(sync_group_strb),
    .resp_group_done(resp_group_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [3:0] strb);
    req_group_valid = 1'b1;
    req_group_strb  = strb;
    chk("offer_ready", 64'(req_group_ready), 64'd1);
    tick();
    req_group_valid = 1'b0;
  endtask

  task automatic finish_group(input string tag);
    chk({tag, "_wait_ready"}, 64'(req_group_ready), 64'd0);
    resp_group_done = 1'b1;
    tick();
    resp_group_done = 1'b0;
    chk({tag, "_idle_ready"}, 64'(req_group_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_group_valid = 1'b0; req_group_strb = 4'b0000;
    req_group_addr = {A3, A2, A1, A0}; req_ready = 2'b11; resp_group_done = 1'b0;
    tick(); tick();
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_sync_valid", 64'(sync_group_valid), 64'd0);
    chk("rst_sync_strb", 64'(sync_group_strb), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 64'(req_group_ready), 64'd1);

    // Full group, both channels always ready; done pulse in DISPATCH is ignored.
    offer(4'b1111);
    chk("g1_c1_sync_valid", 64'(sync_group_valid), 64'd1);
    chk("g1_c1_sync_strb", 64'(sync_group_strb), 64'hF);
    chk("g1_c1_valid", 64'(req_valid), 64'd3);
    chk("g1_c1_tags", 64'(req_tag), 64'h4);
    chk("g1_c1_addr", req_addr, {A1, A0});
    chk("g1_c1_ready", 64'(req_group_ready), 64'd0);
    resp_group_done = 1'b1;
    tick();
    resp_group_done = 1'b0;
    chk("g1_c2_sync_valid", 64'(sync_group_valid), 64'd0);
    chk("g1_c2_valid", 64'(req_valid), 64'd3);
    chk("g1_c2_tags", 64'(req_tag), 64'hE);
    chk("g1_c2_addr", req_addr, {A3, A2});
    tick();
    chk("g1_c3_valid", 64'(req_valid), 64'd0);
    chk("g1_c3_ready", 64'(req_group_ready), 64'd0);
    // Second group offered in WAIT must not be accepted.
    req_group_valid = 1'b1;
    req_group_strb  = 4'b0011;
    tick();
    chk("g1_wait_ready", 64'(req_group_ready), 64'd0);
    chk("g1_wait_valid", 64'(req_valid), 64'd0);
    chk("g1_wait_sync", 64'(sync_group_valid), 64'd0);
    req_group_valid = 1'b0;
    finish_group("g1");
    resp_group_done = 1'b1;
    tick();
    resp_group_done = 1'b0;
    chk("idle_done_ready", 64'(req_group_ready), 64'd1);
    chk("idle_done_valid", 64'(req_valid), 64'd0);

    // Sparse strobe.
    offer(4'b1010);
    chk("g2_c1_valid", 64'(req_valid), 64'd3);
    chk("g2_c1_tags", 64'(req_tag), 64'hD);
    chk("g2_c1_addr", req_addr, {A3, A1});
    chk("g2_c1_sync_strb", 64'(sync_group_strb), 64'hA);
    tick();
    chk("g2_c2_valid", 64'(req_valid), 64'd0);
    finish_group("g2");

    // Channel 1 stalled: it holds tag1/addr1 while channel 0 streams 0,2,3.
    req_ready = 2'b01;
    offer(4'b1111);
    chk("g3_c1_valid", 64'(req_valid), 64'd3);
    chk("g3_c1_tags", 64'(req_tag), 64'h4);
    chk("g3_c1_addr", req_addr, {A1, A0});
    tick();
    chk("g3_c2_valid", 64'(req_valid), 64'd3);
    chk("g3_c2_tags", 64'(req_tag), 64'h6);
    chk("g3_c2_addr", req_addr, {A1, A2});
    tick();
    chk("g3_c3_valid", 64'(req_valid), 64'd3);
    chk("g3_c3_tags", 64'(req_tag), 64'h7);
    chk("g3_c3_addr", req_addr, {A1, A3});
    req_ready = 2'b11;
    tick();
    chk("g3_c4_valid", 64'(req_valid), 64'd0);
    finish_group("g3");

    // Empty group: sync pulse only, then WAIT.
    offer(4'b0000);
    chk("g4_sync_valid", 64'(sync_group_valid), 64'd1);
    chk("g4_sync_strb", 64'(sync_group_strb), 64'h0);
    chk("g4_c1_valid", 64'(req_valid), 64'd0);
    chk("g4_c1_ready", 64'(req_group_ready), 64'd0);
    tick();
    chk("g4_c2_valid", 64'(req_valid), 64'd0);
    chk("g4_c2_sync", 64'(sync_group_valid), 64'd0);
    tick();
    finish_group("g4");

    // Reset mid-DISPATCH with tag 3 pending.
    req_ready = 2'b01;
    offer(4'b1111);
    tick();
    chk("g5_pre_tags", 64'(req_tag), 64'h6);
    rst_n = 1'b0;
    tick();
    chk("g5_rst_valid", 64'(req_valid), 64'd0);
    chk("g5_rst_sync", 64'(sync_group_valid), 64'd0);
    rst_n = 1'b1;
    req_ready = 2'b11;
    chk("g5_rel_ready", 64'(req_group_ready), 64'd1);
    tick();
    chk("g5_post1_valid", 64'(req_valid), 64'd0);
    tick();
    chk("g5_post2_valid", 64'(req_valid), 64'd0);
    chk("g5_post2_ready", 64'(req_group_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
